// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory and the decode stage.
// master = fetch unit side, slave = memory/decode (or bench) side.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i;

  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output instr_valid_o, instr_o, pc_o,
    input  instr_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  instr_valid_o, instr_o, pc_o,
    output instr_ready_i
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues word reads and buffers returned
// instructions with their PCs in an in-order queue feeding decode.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef logic [PW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t DEPTH_C = cnt_t'(DEPTH);

  logic [31:0]                fetch_pc_q, fetch_pc_d;
  logic [DEPTH-1:0][31:0]     slot_pc_q, slot_pc_d;
  logic [DEPTH-1:0][31:0]     slot_instr_q, slot_instr_d;
  logic [DEPTH-1:0]           slot_filled_q, slot_filled_d;
  ptr_t                       wr_ptr_q, wr_ptr_d;
  ptr_t                       fill_ptr_q, fill_ptr_d;
  ptr_t                       rd_ptr_q, rd_ptr_d;
  cnt_t                       reserved_q, reserved_d;
  cnt_t                       outstanding_q, outstanding_d;
  cnt_t                       discard_q, discard_d;

  logic        pop;
  logic        req;
  logic        grant;
  logic        rvalid;
  cnt_t        reserved_after_pop;
  logic [31:0] redirect_target;

  // Handshakes: a request transfers on imem_req_o & imem_gnt_i, an instruction
  // transfers to decode on instr_valid_o & instr_ready_i; a response needs no ready.
  assign pop                = slot_filled_q[rd_ptr_q] & bus.instr_ready_i;
  assign reserved_after_pop = reserved_q - cnt_t'(pop);
  assign req                = !rst_i & !bus.redirect_i & (reserved_after_pop < DEPTH_C);
  assign grant              = req & bus.imem_gnt_i;
  assign rvalid             = bus.imem_rvalid_i;
  assign redirect_target    = bus.redirect_pc_i & 32'hFFFF_FFFC;

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = slot_filled_q[rd_ptr_q];
  assign bus.instr_o       = slot_instr_q[rd_ptr_q];
  assign bus.pc_o          = slot_pc_q[rd_ptr_q];

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    slot_pc_d     = slot_pc_q;
    slot_instr_d  = slot_instr_q;
    slot_filled_d = slot_filled_q;
    wr_ptr_d      = wr_ptr_q;
    fill_ptr_d    = fill_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    reserved_d    = reserved_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;

    if (bus.redirect_i) begin
      // Everything granted before now is stale; its responses are counted off.
      fetch_pc_d    = redirect_target;
      slot_pc_d     = '0;
      slot_instr_d  = '0;
      slot_filled_d = '0;
      wr_ptr_d      = '0;
      fill_ptr_d    = '0;
      rd_ptr_d      = '0;
      reserved_d    = '0;
      outstanding_d = outstanding_q - cnt_t'(rvalid);
      discard_d     = outstanding_q - cnt_t'(rvalid);
    end else begin
      if (pop) begin
        slot_pc_d[rd_ptr_q]     = '0;
        slot_instr_d[rd_ptr_q]  = '0;
        slot_filled_d[rd_ptr_q] = 1'b0;
        rd_ptr_d                = rd_ptr_q + ptr_t'(1);
      end
      if (rvalid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - cnt_t'(1);
        end else begin
          slot_instr_d[fill_ptr_q]  = bus.imem_rdata_i;
          slot_filled_d[fill_ptr_q] = 1'b1;
          fill_ptr_d                = fill_ptr_q + ptr_t'(1);
        end
      end
      // Applied after the pop so a slot freed this cycle can be re-reserved.
      if (grant) begin
        slot_pc_d[wr_ptr_q]     = fetch_pc_q;
        slot_instr_d[wr_ptr_q]  = '0;
        slot_filled_d[wr_ptr_q] = 1'b0;
        wr_ptr_d                = wr_ptr_q + ptr_t'(1);
        fetch_pc_d              = fetch_pc_q + 32'd4;
      end
      reserved_d    = reserved_q + cnt_t'(grant) - cnt_t'(pop);
      outstanding_d = outstanding_q + cnt_t'(grant) - cnt_t'(rvalid);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q    <= RESET_PC;
      slot_pc_q     <= '0;
      slot_instr_q  <= '0;
      slot_filled_q <= '0;
      wr_ptr_q      <= '0;
      fill_ptr_q    <= '0;
      rd_ptr_q      <= '0;
      reserved_q    <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      slot_pc_q     <= slot_pc_d;
      slot_instr_q  <= slot_instr_d;
      slot_filled_q <= slot_filled_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_ptr_q    <= fill_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      reserved_q    <= reserved_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory plus an in-order
// scoreboard of {pc, instr} pairs expected at the decode port.
module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst_i;
  fetch_unit_if bus();

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
  } redir_vec_t;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Control knobs applied by step() at the next falling edge.
  logic        ctl_rst = 1'b1;
  logic        ctl_ready = 1'b1;
  logic        ctl_gnt = 1'b1;
  logic        ctl_redirect = 1'b0;
  logic [31:0] ctl_redirect_pc = '0;
  int          lat = 1;
  logic        lat_rand = 1'b0;

  // Values observed in the last step.
  logic        obs_req, obs_valid, got_grant, popped;
  logic [31:0] obs_addr, obs_pc, obs_instr;

  logic [63:0] exp_q[$];
  logic [31:0] exp_pc = RESET_PC;
  int          resp_due_q[$];
  logic [31:0] resp_data_q[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_5A5A;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    logic [63:0] e;
    int          l;
    @(negedge clk);
    cyc++;
    rst_i             = ctl_rst;
    bus.redirect_i    = ctl_redirect;
    bus.redirect_pc_i = ctl_redirect_pc;
    bus.instr_ready_i = ctl_ready;
    bus.imem_gnt_i    = ctl_gnt;
    if (ctl_rst) begin
      resp_due_q.delete();
      resp_data_q.delete();
    end
    if (!ctl_rst && resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
      void'(resp_due_q.pop_front());
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = resp_data_q.pop_front();
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = $urandom;
    end
    #1;
    obs_req   = bus.imem_req_o;
    obs_addr  = bus.imem_addr_o;
    obs_valid = bus.instr_valid_o;
    obs_pc    = bus.pc_o;
    obs_instr = bus.instr_o;
    got_grant = obs_req & ctl_gnt;
    popped    = obs_valid & ctl_ready;
    if (ctl_rst) begin
      exp_q.delete();
      exp_pc = RESET_PC;
    end else begin
      if (popped) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pop: got pc %h with no entry expected (cycle %0d)", obs_pc, cyc);
        end else begin
          e = exp_q.pop_front();
          check32("pop_pc", obs_pc, e[63:32]);
          check32("pop_instr", obs_instr, e[31:0]);
        end
      end
      if (ctl_redirect) check32("req_during_redirect", {31'd0, obs_req}, 32'd0);
      if (got_grant) begin
        check32("grant_addr", obs_addr, exp_pc);
        exp_q.push_back({exp_pc, mem_word(exp_pc)});
        l = lat_rand ? int'($urandom_range(1, 3)) : lat;
        resp_due_q.push_back(cyc + l);
        resp_data_q.push_back(mem_word(obs_addr));
        exp_pc = exp_pc + 32'd4;
      end
      if (ctl_redirect) begin
        exp_q.delete();
        exp_pc = ctl_redirect_pc & 32'hFFFF_FFFC;
      end
    end
  endtask

  initial begin
    redir_vec_t vecs[5];
    int npop;
    int first_pop;
    int ngrant;
    logic [31:0] hold_addr;
    logic        seen;

    vecs[0] = '{target: 32'h0000_1002, exp_addr: 32'h0000_1000};
    vecs[1] = '{target: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
    vecs[2] = '{target: 32'h0000_0003, exp_addr: 32'h0000_0000};
    vecs[3] = '{target: 32'h8000_0005, exp_addr: 32'h8000_0004};
    vecs[4] = '{target: 32'h1234_5679, exp_addr: 32'h1234_5678};

    rst_i = 1'b1;
    bus.imem_gnt_i = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i = '0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    bus.instr_ready_i = 1'b0;

    // Reset values.
    step(); step();
    check32("rst_req", {31'd0, obs_req}, 32'd0);
    check32("rst_addr", obs_addr, RESET_PC);
    check32("rst_valid", {31'd0, obs_valid}, 32'd0);
    check32("rst_instr", obs_instr, 32'd0);
    check32("rst_pc", obs_pc, 32'd0);

    // Streaming: same-cycle grant, 1-cycle response, decode always ready.
    ctl_rst = 1'b0;
    npop = 0;
    first_pop = -1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (i < 3) begin
        check32("stream_req", {31'd0, obs_req}, 32'd1);
        check32("stream_addr", obs_addr, RESET_PC + 32'(4 * i));
      end
      if (popped) begin
        npop++;
        if (first_pop < 0) first_pop = i;
      end
    end
    check32("first_pop_cycle", 32'(first_pop), 32'd2);
    check32("stream_pops", 32'(npop), 32'd8);

    // Backpressure: decode stalled for 10 cycles after a redirect.
    ctl_ready = 1'b0;
    ctl_redirect = 1'b1;
    ctl_redirect_pc = 32'h0000_0200;
    step();
    ctl_redirect = 1'b0;
    ngrant = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (got_grant) ngrant++;
    end
    check32("stall_grants", 32'(ngrant), 32'd2);
    check32("stall_req_low", {31'd0, obs_req}, 32'd0);
    ctl_ready = 1'b1;
    npop = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (popped) npop++;
    end
    check32("release_pops", 32'(npop), 32'd12);

    // Redirect to 0x1002 with two requests outstanding.
    ctl_gnt = 1'b0;
    repeat (3) step();
    lat = 3;
    ctl_gnt = 1'b1;
    ctl_redirect = 1'b1;
    ctl_redirect_pc = 32'h0000_0040;
    step();
    ctl_redirect = 1'b0;
    step(); step();
    ctl_redirect = 1'b1;
    ctl_redirect_pc = 32'h0000_1002;
    step();
    ctl_redirect = 1'b0;
    step();
    check32("redir_req", {31'd0, obs_req}, 32'd1);
    check32("redir_addr", obs_addr, 32'h0000_1000);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (popped) begin
        seen = 1'b1;
        check32("redir_first_pc", obs_pc, 32'h0000_1000);
      end else begin
        step();
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $display("FAIL redir_first_pop: got no pop within 20 cycles, required pc 00001000");
    end

    // Redirect colliding with a response and a pop.
    lat = 1;
    repeat (8) step();
    ctl_redirect = 1'b1;
    ctl_redirect_pc = 32'h0000_2000;
    step();
    check32("collide_pop", {31'd0, popped}, 32'd1);
    check32("collide_rvalid", {31'd0, bus.imem_rvalid_i}, 32'd1);
    ctl_redirect = 1'b0;
    step();
    check32("collide_valid", {31'd0, obs_valid}, 32'd0);
    check32("collide_req", {31'd0, obs_req}, 32'd1);
    check32("collide_addr", obs_addr, 32'h0000_2000);
    repeat (4) step();

    // Grant stalled for 5 cycles.
    ctl_gnt = 1'b0;
    step();
    hold_addr = exp_pc;
    for (int i = 0; i < 5; i++) begin
      step();
      check32("stall_addr", obs_addr, hold_addr);
      check32("stall_req", {31'd0, obs_req}, 32'd1);
    end
    ctl_gnt = 1'b1;
    step();
    step();
    check32("after_stall_addr", obs_addr, hold_addr + 32'd4);

    // Reset with a full queue and one request outstanding.
    ctl_rst = 1'b1;
    step(); step();
    ctl_rst = 1'b0;
    ctl_ready = 1'b0;
    lat = 2;
    step(); step(); step();
    check32("full_req", {31'd0, obs_req}, 32'd0);
    ctl_rst = 1'b1;
    step();
    check32("pre_rst_valid", {31'd0, obs_valid}, 32'd1);
    check32("pre_rst_pc", obs_pc, RESET_PC);
    step();
    check32("mid_rst_req", {31'd0, obs_req}, 32'd0);
    check32("mid_rst_valid", {31'd0, obs_valid}, 32'd0);
    check32("mid_rst_instr", obs_instr, 32'd0);
    check32("mid_rst_pc", obs_pc, 32'd0);
    check32("mid_rst_addr", obs_addr, RESET_PC);
    ctl_rst = 1'b0;
    ctl_ready = 1'b1;
    lat = 1;
    step();
    check32("resume_req", {31'd0, obs_req}, 32'd1);
    check32("resume_addr", obs_addr, RESET_PC);
    repeat (6) step();

    // Redirect targets from the table, including wrap past 0xFFFF_FFFC.
    for (int v = 0; v < 5; v++) begin
      ctl_redirect = 1'b1;
      ctl_redirect_pc = vecs[v].target;
      step();
      ctl_redirect = 1'b0;
      step();
      check32("tbl_valid", {31'd0, obs_valid}, 32'd0);
      check32("tbl_req", {31'd0, obs_req}, 32'd1);
      check32("tbl_addr", obs_addr, vecs[v].exp_addr);
      step();
      check32("tbl_next_addr", obs_addr, vecs[v].exp_addr + 32'd4);
      repeat (5) step();
    end

    // Random grants, backpressure, latency and redirects.
    lat_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      ctl_ready = ($urandom_range(0, 3) != 0);
      ctl_gnt = ($urandom_range(0, 2) != 0);
      ctl_redirect = ($urandom_range(0, 19) == 0);
      ctl_redirect_pc = $urandom;
      step();
    end

    // Drain: everything granted must reach decode.
    ctl_redirect = 1'b0;
    ctl_gnt = 1'b0;
    ctl_ready = 1'b1;
    repeat (12) step();
    check32("drain_empty", 32'(exp_q.size()), 32'd0);
    check32("drain_valid", {31'd0, obs_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
